beat_tempo_estimator: RTL and testbench

BEAT_TEMPO_ESTIMATOR -- requirements
Module: beat_tempo_estimator

---
 rtl/baton_pkg.sv | 14 +
 rtl/interval_avg4.sv | 73 +++++++
 rtl/beat_tempo_estimator.sv | 129 ++++++++++++
 tb/tb_beat_tempo_estimator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/baton_pkg.sv
// Shared types and constants for the beat tempo estimator.
package baton_pkg;

    // Default width of the interval counter and of the period output.
    localparam int BEAT_CNT_W = 24;

    // Tracking state: nothing seen, buffer filling, buffer full.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_TRACK = 2'd2
    } beat_state_e;

endpackage

// File: rtl/interval_avg4.sv
// Four-entry circular interval buffer with a two-stage moving average.
// The sum is formed from the buffer contents as they will be after the
// current write, so the averaged value appears two cycles after the strobe.
module interval_avg4
    import baton_pkg::*;
#(
    parameter int W = BEAT_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,       // drop pointer and validity (tracking lost)
    input  logic         i_wr,        // store i_interval at the write pointer
    input  logic         i_full,      // this write leaves four valid entries
    input  logic [W-1:0] i_interval,
    output logic [W-1:0] o_avg,
    output logic         o_valid
);

    logic [W-1:0] r_buf [4];
    logic [1:0]   r_ptr;
    logic [W+1:0] r_sum;
    logic         r_sum_vld;
    logic [W-1:0] r_avg;
    logic         r_valid;
    logic [W+1:0] w_sum_next;

    // Sum of the buffer with the incoming interval substituted at the pointer.
    always_comb begin
        w_sum_next = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_ptr == 2'(i)) begin
                w_sum_next = w_sum_next + {2'b00, i_interval};
            end else begin
                w_sum_next = w_sum_next + {2'b00, r_buf[i]};
            end
        end
    end

    // Buffer write, sum stage and divide-by-four stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
            r_ptr     <= '0;
            r_sum     <= '0;
            r_sum_vld <= 1'b0;
            r_avg     <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_sum_vld <= 1'b0;
            if (i_clr) begin
                r_ptr   <= '0;
                r_valid <= 1'b0;
            end else begin
                if (i_wr) begin
                    r_buf[r_ptr] <= i_interval;
                    r_ptr        <= r_ptr + 2'd1;
                    r_sum        <= w_sum_next;
                    r_sum_vld    <= i_full;
                end
                if (r_sum_vld) begin
                    r_avg   <= W'(r_sum >> 2);
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign o_avg   = r_avg;
    assign o_valid = r_valid;

endmodule

// File: rtl/beat_tempo_estimator.sv
// Beat tempo estimator: measures the spacing of baton direction-change
// pulses, averages the last four intervals and emits subdivision ticks
// phase-locked to incoming beats.
module beat_tempo_estimator
    import baton_pkg::*;
#(
    parameter int CNT_W       = BEAT_CNT_W,
    parameter int MIN_BEAT    = 16,
    parameter int MAX_BEAT    = 2**CNT_W - 1,
    parameter int SUBDIV_LOG2 = 2
) (
    input  logic             clk_camera_in,
    input  logic             rst_in,
    input  logic             beat_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid_out,
    output logic             tick_out,
    output logic             timeout_out,
    output logic [1:0]       state_dbg_out
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_BEAT);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BEAT);

    beat_state_e      r_state;
    beat_state_e      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_fill;
    logic             r_timeout;
    logic [CNT_W-1:0] r_phase;

    logic             w_timeout;
    logic             w_accept;
    logic             w_store;
    logic             w_realign;
    logic             w_full;
    logic [CNT_W-1:0] w_avg;
    logic             w_avg_valid;
    logic [CNT_W-1:0] w_sub;
    logic             w_wrap;

    // Beat qualification: debounce outside IDLE, and a timeout beat restarts
    // the sequence instead of being stored.
    always_comb begin
        w_timeout = (r_state != ST_IDLE) && (r_cnt == MAX_C);
        w_accept  = beat_in && ((r_state == ST_IDLE) || (r_cnt >= MIN_C));
        w_store   = w_accept && (r_state != ST_IDLE) && !w_timeout;
        w_realign = w_store && (r_state == ST_TRACK);
        w_full    = (r_fill >= 3'd3);
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_PRIME;
            end
            ST_PRIME: begin
                if (w_timeout) w_state_next = beat_in ? ST_PRIME : ST_IDLE;
                else if (w_store && (r_fill == 3'd3)) w_state_next = ST_TRACK;
            end
            ST_TRACK: begin
                if (w_timeout) w_state_next = beat_in ? ST_PRIME : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register, interval counter, fill count and timeout pulse.
    always_ff @(posedge clk_camera_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_fill    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timeout <= w_timeout;
            if (w_accept) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != MAX_C) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_timeout) begin
                r_fill <= '0;
            end else if (w_store && (r_fill != 3'd4)) begin
                r_fill <= r_fill + 3'd1;
            end
        end
    end

    interval_avg4 #(
        .W (CNT_W)
    ) u_avg (
        .i_clk      (clk_camera_in),
        .i_rst      (rst_in),
        .i_clr      (w_timeout),
        .i_wr       (w_store),
        .i_full     (w_full),
        .i_interval (r_cnt),
        .o_avg      (w_avg),
        .o_valid    (w_avg_valid)
    );

    // Subdivision wrap detection; >= keeps the phase bounded if the period shrinks.
    always_comb begin
        w_sub  = period_out >> SUBDIV_LOG2;
        w_wrap = period_valid_out && (w_sub != '0) && (r_phase >= w_sub - CNT_W'(1));
    end

    // Phase counter: held at zero while invalid, restarted on wrap or beat.
    always_ff @(posedge clk_camera_in) begin
        if (rst_in) begin
            r_phase <= '0;
        end else if (!period_valid_out || w_realign || w_wrap) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + CNT_W'(1);
        end
    end

    assign period_out       = w_avg;
    assign period_valid_out = w_avg_valid;
    assign tick_out         = period_valid_out && (w_sub != '0) && (w_realign || w_wrap);
    assign timeout_out      = r_timeout;
    assign state_dbg_out    = r_state;

endmodule

// File: tb/tb_beat_tempo_estimator.sv
// Directed bench for beat_tempo_estimator with CNT_W=10, MIN_BEAT=16,
// MAX_BEAT=1023, SUBDIV_LOG2=2.
module tb_beat_tempo_estimator;
    import baton_pkg::*;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       beat_in = 1'b0;
    logic [9:0] period_out;
    logic       period_valid_out;
    logic       tick_out;
    logic       timeout_out;
    logic [1:0] state_dbg_out;

    int n_checks = 0;
    int n_fail   = 0;

    beat_tempo_estimator #(
        .CNT_W       (10),
        .MIN_BEAT    (16),
        .MAX_BEAT    (1023),
        .SUBDIV_LOG2 (2)
    ) dut (
        .clk_camera_in    (clk),
        .rst_in           (rst_in),
        .beat_in          (beat_in),
        .period_out       (period_out),
        .period_valid_out (period_valid_out),
        .tick_out         (tick_out),
        .timeout_out      (timeout_out),
        .state_dbg_out    (state_dbg_out)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks: inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_beat();
        beat_in = 1'b1;
        step();
        beat_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in  = 1'b1;
        beat_in = 1'b0;
        idle(3);
        n_checks++; if (period_out !== 10'd0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period_out); end
        n_checks++; if (period_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", period_valid_out); end
        n_checks++; if (tick_out !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick_out); end
        n_checks++; if (timeout_out !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_out); end
        n_checks++; if (state_dbg_out !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg_out, ST_IDLE); end
        rst_in = 1'b0;
        step();
    endtask

    // Five beats 100 apart, then one more beat with tick spacing checks.
    task automatic test_steady();
        for (int b = 0; b < 4; b++) begin
            pulse_beat();
            idle(99);
        end
        pulse_beat();
        n_checks++; if (state_dbg_out !== ST_TRACK) begin n_fail++; $display("FAIL steady_state: got %0d expected %0d", state_dbg_out, ST_TRACK); end
        n_checks++; if (period_valid_out !== 1'b0) begin n_fail++; $display("FAIL steady_valid_early: got %b expected 0", period_valid_out); end
        step();
        n_checks++; if (period_valid_out !== 1'b1) begin n_fail++; $display("FAIL steady_valid: got %b expected 1", period_valid_out); end
        n_checks++; if (period_out !== 10'd100) begin n_fail++; $display("FAIL steady_period: got %0d expected 100", period_out); end
        idle(98);
        beat_in = 1'b1;
        #1;
        n_checks++; if (tick_out !== 1'b1) begin n_fail++; $display("FAIL steady_realign_tick: got %b expected 1", tick_out); end
        step();
        beat_in = 1'b0;
        for (int o = 1; o < 100; o++) begin
            n_checks++;
            if (tick_out !== ((o % 25) == 0)) begin
                n_fail++;
                $display("FAIL steady_tick_o%0d: got %b expected %b", o, tick_out, ((o % 25) == 0));
            end
            step();
        end
        n_checks++; if (period_out !== 10'd100) begin n_fail++; $display("FAIL steady_period_hold: got %0d expected 100", period_out); end
    endtask

    // Interval 120 replaces one 100: (100+100+100+120)/4 = 105, sub = 26.
    task automatic test_realign_avg();
        idle(20);
        beat_in = 1'b1;
        #1;
        n_checks++; if (tick_out !== 1'b1) begin n_fail++; $display("FAIL avg_realign_tick: got %b expected 1", tick_out); end
        step();
        beat_in = 1'b0;
        for (int o = 1; o <= 30; o++) begin
            if (o == 1) begin
                n_checks++; if (period_out !== 10'd100) begin n_fail++; $display("FAIL avg_period_latency: got %0d expected 100", period_out); end
            end
            if (o == 2) begin
                n_checks++; if (period_out !== 10'd105) begin n_fail++; $display("FAIL avg_period: got %0d expected 105", period_out); end
            end
            n_checks++;
            if (tick_out !== (o == 26)) begin
                n_fail++;
                $display("FAIL avg_tick_o%0d: got %b expected %b", o, tick_out, (o == 26));
            end
            step();
        end
    endtask

    // A beat 5 cycles after an accepted one must not restart the interval.
    task automatic test_debounce();
        idle(69);
        pulse_beat();
        idle(4);
        beat_in = 1'b1;
        #1;
        n_checks++; if (tick_out !== 1'b0) begin n_fail++; $display("FAIL debounce_tick: got %b expected 0", tick_out); end
        step();
        beat_in = 1'b0;
        n_checks++; if (state_dbg_out !== ST_TRACK) begin n_fail++; $display("FAIL debounce_state: got %0d expected %0d", state_dbg_out, ST_TRACK); end
        idle(2);
        n_checks++; if (period_out !== 10'd105) begin n_fail++; $display("FAIL debounce_period_hold: got %0d expected 105", period_out); end
        idle(52);
        pulse_beat();
        step();
        // buffer {100,120,100,60} -> 95
        n_checks++; if (period_out !== 10'd95) begin n_fail++; $display("FAIL debounce_period: got %0d expected 95", period_out); end
    endtask

    // Silence in TRACK until the counter saturates.
    task automatic test_timeout();
        int early;
        int ticks;
        early = 0;
        ticks = 0;
        for (int c = 2; c < 1024; c++) begin
            if (timeout_out !== 1'b0) early++;
            step();
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL timeout_early: got %0d expected 0", early); end
        n_checks++; if (timeout_out !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 1", timeout_out); end
        n_checks++; if (period_valid_out !== 1'b0) begin n_fail++; $display("FAIL timeout_valid: got %b expected 0", period_valid_out); end
        n_checks++; if (state_dbg_out !== ST_IDLE) begin n_fail++; $display("FAIL timeout_state: got %0d expected %0d", state_dbg_out, ST_IDLE); end
        step();
        n_checks++; if (timeout_out !== 1'b0) begin n_fail++; $display("FAIL timeout_width: got %b expected 0", timeout_out); end
        for (int c = 0; c < 50; c++) begin
            if (tick_out !== 1'b0) ticks++;
            step();
        end
        n_checks++; if (ticks !== 0) begin n_fail++; $display("FAIL timeout_ticks: got %0d expected 0", ticks); end
        pulse_beat();
        n_checks++; if (state_dbg_out !== ST_PRIME) begin n_fail++; $display("FAIL timeout_rearm: got %0d expected %0d", state_dbg_out, ST_PRIME); end
    endtask

    // Beat landing exactly on the timeout cycle starts a fresh sequence.
    task automatic test_timeout_beat();
        for (int b = 0; b < 4; b++) begin
            idle(99);
            pulse_beat();
        end
        n_checks++; if (state_dbg_out !== ST_TRACK) begin n_fail++; $display("FAIL tbeat_track: got %0d expected %0d", state_dbg_out, ST_TRACK); end
        idle(1022);
        pulse_beat();
        n_checks++; if (state_dbg_out !== ST_PRIME) begin n_fail++; $display("FAIL tbeat_state: got %0d expected %0d", state_dbg_out, ST_PRIME); end
        n_checks++; if (dut.r_cnt !== 10'd1) begin n_fail++; $display("FAIL tbeat_counter: got %0d expected 1", dut.r_cnt); end
        n_checks++; if (timeout_out !== 1'b1) begin n_fail++; $display("FAIL tbeat_timeout: got %b expected 1", timeout_out); end
        n_checks++; if (period_valid_out !== 1'b0) begin n_fail++; $display("FAIL tbeat_valid: got %b expected 0", period_valid_out); end
        for (int b = 0; b < 3; b++) begin
            idle(99);
            pulse_beat();
        end
        n_checks++; if (state_dbg_out !== ST_PRIME) begin n_fail++; $display("FAIL tbeat_fill_cleared: got %0d expected %0d", state_dbg_out, ST_PRIME); end
        idle(99);
        pulse_beat();
        n_checks++; if (state_dbg_out !== ST_TRACK) begin n_fail++; $display("FAIL tbeat_retrack: got %0d expected %0d", state_dbg_out, ST_TRACK); end
    endtask

    // Reset on a beat cycle in TRACK, then re-prime at period 50.
    task automatic test_reset_mid();
        idle(2);
        n_checks++; if (period_valid_out !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b expected 1", period_valid_out); end
        idle(97);
        beat_in = 1'b1;
        rst_in  = 1'b1;
        step();
        beat_in = 1'b0;
        rst_in  = 1'b0;
        n_checks++; if (period_out !== 10'd0) begin n_fail++; $display("FAIL rmid_period: got %0d expected 0", period_out); end
        n_checks++; if (period_valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", period_valid_out); end
        n_checks++; if (tick_out !== 1'b0) begin n_fail++; $display("FAIL rmid_tick: got %b expected 0", tick_out); end
        n_checks++; if (timeout_out !== 1'b0) begin n_fail++; $display("FAIL rmid_timeout: got %b expected 0", timeout_out); end
        n_checks++; if (state_dbg_out !== ST_IDLE) begin n_fail++; $display("FAIL rmid_state: got %0d expected %0d", state_dbg_out, ST_IDLE); end
        step();
        n_checks++; if (tick_out !== 1'b0) begin n_fail++; $display("FAIL rmid_tick_after: got %b expected 0", tick_out); end
        n_checks++; if (timeout_out !== 1'b0) begin n_fail++; $display("FAIL rmid_timeout_after: got %b expected 0", timeout_out); end
        for (int b = 0; b < 4; b++) begin
            pulse_beat();
            idle(49);
        end
        n_checks++; if (period_valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_3int: got %b expected 0", period_valid_out); end
        pulse_beat();
        step();
        n_checks++; if (period_valid_out !== 1'b1) begin n_fail++; $display("FAIL rmid_valid_4int: got %b expected 1", period_valid_out); end
        n_checks++; if (period_out !== 10'd50) begin n_fail++; $display("FAIL rmid_period_50: got %0d expected 50", period_out); end
    endtask

    // Sequence and final report.
    initial begin
        test_reset();
        test_steady();
        test_realign_avg();
        test_debounce();
        test_timeout();
        test_timeout_beat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
